// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: opcodes,
// state enumeration, datapath mux-select encodings and the decode helper.
package multicycle_control_pkg;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_LUI      = 4'd5,
        S_AUIPC    = 4'd6,
        S_WB_ALU   = 4'd7,
        S_MEM_ADDR = 4'd8,
        S_MEM_RD   = 4'd9,
        S_WB_MEM   = 4'd10,
        S_MEM_WR   = 4'd11,
        S_BRANCH   = 4'd12,
        S_JAL      = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

    // ALU A operand select
    localparam logic [1:0] ALUSRC_A_RS1   = 2'b00;
    localparam logic [1:0] ALUSRC_A_OLDPC = 2'b01;
    localparam logic [1:0] ALUSRC_A_ZERO  = 2'b10;
    localparam logic [1:0] ALUSRC_A_PC    = 2'b11;

    // ALU B operand select
    localparam logic [1:0] ALUSRC_B_RS2   = 2'b00;
    localparam logic [1:0] ALUSRC_B_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRC_B_IMM   = 2'b10;

    // Register writeback source select
    localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
    localparam logic [1:0] MEMTOREG_PC     = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // State that follows DECODE for a given opcode; disabled or unknown
    // opcodes (including any with IR[1:0] != 2'b11) land in TRAP.
    function automatic state_e decode_target(input logic [6:0] op,
                                             input logic       has_jal,
                                             input logic       has_u);
        state_e s;
        case (op)
            OP_R:              s = S_EXEC_R;
            OP_I:              s = S_EXEC_I;
            OP_LOAD, OP_STORE: s = S_MEM_ADDR;
            OP_BRANCH:         s = S_BRANCH;
            OP_JAL:            s = has_jal ? S_JAL : S_TRAP;
            OP_LUI:            s = has_u ? S_LUI : S_TRAP;
            OP_AUIPC:          s = has_u ? S_AUIPC : S_TRAP;
            default:           s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: Moore FSM stepping fetch, decode,
// execute, memory and writeback over a shared memory port and ALU.
//
// Memory handshake: mem_req stays high for as long as the FSM sits in a
// memory state; the access completes in the cycle where mem_req and
// mem_ready are both high at the rising edge. mem_ready is ignored
// whenever mem_req is low.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter bit HAS_JAL = 1'b1,
    parameter bit HAS_U   = 1'b1,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               mdr_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               pc_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic [1:0]         mem_to_reg,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] alu_op_c;

    // Next-state sequencing; memory states hold until mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:    state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE:   state_d = decode_target(opcode, HAS_JAL, HAS_U);
            S_EXEC_R,
            S_EXEC_I,
            S_LUI,
            S_AUIPC:    state_d = S_WB_ALU;
            S_WB_ALU,
            S_WB_MEM,
            S_BRANCH,
            S_JAL:      state_d = S_FETCH;
            S_MEM_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_RESET;
        endcase
    end

    // State register; reset drops every decoded output at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode from the state register. The only mem_ready terms are
    // the completion strobes (ir_write/pc_write, mdr_write) of the access
    // that is finishing this cycle.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = ALUSRC_A_RS1;
        alu_src_b     = ALUSRC_B_RS2;
        alu_op_c      = ALUOP_ADD;
        reg_write     = 1'b0;
        mem_to_reg    = MEMTOREG_ALUOUT;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = ALUSRC_A_PC;
                alu_src_b = ALUSRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                // ALUOut <= oldPC + imm: branch / JAL target
                alu_src_a = ALUSRC_A_OLDPC;
                alu_src_b = ALUSRC_B_IMM;
            end
            S_EXEC_R: begin
                alu_op_c = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_b = ALUSRC_B_IMM;
                alu_op_c  = ALUOP_FUNCT;
            end
            S_LUI: begin
                alu_src_a = ALUSRC_A_ZERO;
                alu_src_b = ALUSRC_B_IMM;
            end
            S_AUIPC: begin
                alu_src_a = ALUSRC_A_OLDPC;
                alu_src_b = ALUSRC_B_IMM;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_b = ALUSRC_B_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) mdr_write = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = MEMTOREG_MDR;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_BRANCH: begin
                alu_op_c      = ALUOP_BRANCH;
                pc_write_cond = 1'b1;
                pc_src        = 1'b1;
            end
            S_JAL: begin
                // PC already holds oldPC+4 from FETCH: link it, jump to ALUOut
                reg_write  = 1'b1;
                mem_to_reg = MEMTOREG_PC;
                pc_write   = 1'b1;
                pc_src     = 1'b1;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_op    = ALUOP_W'(alu_op_c);
    assign dbg_state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: reset checks, a table of instructions with
// hand-derived cycle/strobe counts, a per-cycle reference model driven by
// random instructions and wait states, and trap / mid-access reset cases.
`timescale 1ns/1ps
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       mdr_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic       reg_write;
        logic [1:0] m2r;
        logic       illegal;
    } ctl_t;
    localparam int OW = $bits(ctl_t);

    typedef struct {
        logic [6:0] op;
        int         fw;
        int         mw;
        int         cyc;
        int         rw;
        int         mdr;
        int         we;
    } vec_t;

    // ---------------- clock / reset / DUTs ----------------
    logic       clk = 1'b0;
    logic       rst1_n = 1'b0;
    logic       rst2_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    int         sel = 0;

    always #5 clk = ~clk;

    logic       m1_req, m1_we, m1_iord, m1_irw, m1_mdrw, m1_pcw, m1_pcwc, m1_pcsrc;
    logic [1:0] m1_a, m1_b, m1_op, m1_m2r;
    logic       m1_rw, m1_ill;
    logic [3:0] m1_st;
    logic       m2_req, m2_we, m2_iord, m2_irw, m2_mdrw, m2_pcw, m2_pcwc, m2_pcsrc;
    logic [1:0] m2_a, m2_b, m2_op, m2_m2r;
    logic       m2_rw, m2_ill;
    logic [3:0] m2_st;

    multicycle_control dut1 (
        .clk(clk), .rst_n(rst1_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(m1_req), .mem_we(m1_we), .iord(m1_iord), .ir_write(m1_irw),
        .mdr_write(m1_mdrw), .pc_write(m1_pcw), .pc_write_cond(m1_pcwc),
        .pc_src(m1_pcsrc), .alu_src_a(m1_a), .alu_src_b(m1_b), .alu_op(m1_op),
        .reg_write(m1_rw), .mem_to_reg(m1_m2r), .illegal(m1_ill), .dbg_state(m1_st)
    );

    multicycle_control #(.HAS_JAL(1'b0), .HAS_U(1'b0)) dut2 (
        .clk(clk), .rst_n(rst2_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(m2_req), .mem_we(m2_we), .iord(m2_iord), .ir_write(m2_irw),
        .mdr_write(m2_mdrw), .pc_write(m2_pcw), .pc_write_cond(m2_pcwc),
        .pc_src(m2_pcsrc), .alu_src_a(m2_a), .alu_src_b(m2_b), .alu_op(m2_op),
        .reg_write(m2_rw), .mem_to_reg(m2_m2r), .illegal(m2_ill), .dbg_state(m2_st)
    );

    logic [OW-1:0] w1, w2, wsel;
    ctl_t          cur;
    assign w1 = {m1_st, m1_req, m1_we, m1_iord, m1_irw, m1_mdrw, m1_pcw, m1_pcwc,
                 m1_pcsrc, m1_a, m1_b, m1_op, m1_rw, m1_m2r, m1_ill};
    assign w2 = {m2_st, m2_req, m2_we, m2_iord, m2_irw, m2_mdrw, m2_pcw, m2_pcwc,
                 m2_pcsrc, m2_a, m2_b, m2_op, m2_rw, m2_m2r, m2_ill};
    assign wsel = (sel == 1) ? w2 : w1;
    assign cur  = wsel;

    // ---------------- scoreboard ----------------
    int            tests = 0;
    int            fails = 0;
    logic [OW-1:0] exp_q[$];
    logic          rdy_q[$];

    task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                     name, got, exp, got[OW-1 -: 4], exp[OW-1 -: 4]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic ctl_t blank(input state_e s);
        ctl_t c = '0;
        c.st = s;
        return c;
    endfunction

    task automatic push(input ctl_t c, input logic rdy);
        exp_q.push_back(c);
        rdy_q.push_back(rdy);
    endtask

    // mem_ready is don't-care here, so toggle it randomly
    task automatic push_free(input ctl_t c);
        push(c, 1'($urandom_range(0, 1)));
    endtask

    // Expected per-cycle outputs for one instruction, from its FETCH on.
    task automatic model_instr(input logic [6:0] op, input int fw, input int mw,
                               input bit has_jal, input bit has_u, input int trap_len);
        ctl_t c;
        bit   is_store;
        for (int i = 0; i <= fw; i++) begin
            c = blank(S_FETCH);
            c.mem_req = 1'b1; c.a = 2'b11; c.b = 2'b01;
            c.ir_write = (i == fw); c.pc_write = (i == fw);
            push(c, i == fw);
        end
        c = blank(S_DECODE); c.a = 2'b01; c.b = 2'b10; push_free(c);
        if (op == 7'b0110011 || op == 7'b0010011 ||
            (has_u && (op == 7'b0110111 || op == 7'b0010111))) begin
            case (op)
                7'b0110011: begin c = blank(S_EXEC_R); c.op = 2'b10; end
                7'b0010011: begin c = blank(S_EXEC_I); c.b = 2'b10; c.op = 2'b10; end
                7'b0110111: begin c = blank(S_LUI); c.a = 2'b10; c.b = 2'b10; end
                default:    begin c = blank(S_AUIPC); c.a = 2'b01; c.b = 2'b10; end
            endcase
            push_free(c);
            c = blank(S_WB_ALU); c.reg_write = 1'b1; push_free(c);
        end else if (op == 7'b0000011 || op == 7'b0100011) begin
            is_store = (op == 7'b0100011);
            c = blank(S_MEM_ADDR); c.b = 2'b10; push_free(c);
            for (int i = 0; i <= mw; i++) begin
                c = blank(is_store ? S_MEM_WR : S_MEM_RD);
                c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = is_store;
                c.mdr_write = !is_store && (i == mw);
                push(c, i == mw);
            end
            if (!is_store) begin
                c = blank(S_WB_MEM); c.reg_write = 1'b1; c.m2r = 2'b01; push_free(c);
            end
        end else if (op == 7'b1100011) begin
            c = blank(S_BRANCH); c.op = 2'b01; c.pc_write_cond = 1'b1; c.pc_src = 1'b1;
            push_free(c);
        end else if (op == 7'b1101111 && has_jal) begin
            c = blank(S_JAL); c.reg_write = 1'b1; c.m2r = 2'b10;
            c.pc_write = 1'b1; c.pc_src = 1'b1;
            push_free(c);
        end else begin
            for (int i = 0; i < trap_len; i++) begin
                c = blank(S_TRAP); c.illegal = 1'b1; push_free(c);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_q(input string name);
        logic [OW-1:0] e;
        logic          r;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rdy_q.pop_front();
            @(negedge clk);
            mem_ready = r;
            #1;
            check(name, wsel, e);
        end
    endtask

    task automatic do_reset(input int which);
        sel = which;
        @(negedge clk);
        if (which == 1) rst2_n = 1'b0; else rst1_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("reset_hold", wsel, blank(S_RESET));
        @(negedge clk);
        if (which == 1) rst2_n = 1'b1; else rst1_n = 1'b1;
        #1;
        check("reset_release", wsel, blank(S_RESET));
    endtask

    // Reactive driver: waits fw cycles in FETCH and mw in the memory state,
    // then counts cycles and strobes until the DUT is back in FETCH.
    task automatic run_fixed(input string name, input vec_t v);
        int cyc = 0, fcnt = 0, mcnt = 0, rw = 0, mdr = 0, we = 0;
        bit left = 1'b0, done = 1'b0;
        opcode = v.op;
        @(negedge clk);
        check_int({name, "_start"}, int'(cur.st), int'(S_FETCH));
        while (!done && cyc < 60) begin
            if (cur.st == S_FETCH) begin
                mem_ready = (fcnt >= v.fw); fcnt++;
            end else if (cur.st == S_MEM_RD || cur.st == S_MEM_WR) begin
                mem_ready = (mcnt >= v.mw); mcnt++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (cur.reg_write) rw++;
            if (cur.mdr_write) mdr++;
            if (cur.mem_we && cur.mem_req) we++;
            cyc++;
            @(negedge clk);
            if (cur.st != S_FETCH) left = 1'b1;
            else if (left) done = 1'b1;
        end
        mem_ready = 1'b0;
        check_int({name, "_cycles"}, cyc, v.cyc);
        check_int({name, "_reg_write"}, rw, v.rw);
        check_int({name, "_mdr_write"}, mdr, v.mdr);
        check_int({name, "_mem_we"}, we, v.we);
    endtask

    // ---------------- test sequence ----------------
    logic [6:0] legal_ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};

    initial begin
        vec_t tbl [10];
        ctl_t c;
        int   guard;
        logic [6:0] op;

        tbl[0] = '{7'b0110011, 0, 0, 4, 1, 0, 0};   // R-type
        tbl[1] = '{7'b0000011, 2, 3, 10, 1, 1, 0};  // load, 2+3 waits
        tbl[2] = '{7'b0100011, 0, 2, 6, 0, 0, 3};   // store, 2 waits
        tbl[3] = '{7'b1100011, 0, 0, 3, 0, 0, 0};   // branch
        tbl[4] = '{7'b1101111, 0, 0, 3, 1, 0, 0};   // JAL
        tbl[5] = '{7'b0010011, 1, 0, 5, 1, 0, 0};   // I-type, 1 fetch wait
        tbl[6] = '{7'b0110111, 0, 0, 4, 1, 0, 0};   // LUI
        tbl[7] = '{7'b0010111, 3, 0, 7, 1, 0, 0};   // AUIPC, 3 fetch waits
        tbl[8] = '{7'b0000011, 0, 0, 5, 1, 1, 0};   // load, no waits
        tbl[9] = '{7'b0100011, 0, 0, 4, 0, 0, 1};   // store, no waits

        // Reset then R-type with ready tied high, cycle by cycle
        do_reset(0);
        opcode = 7'b0110011;
        model_instr(7'b0110011, 0, 0, 1'b1, 1'b1, 0);
        run_q("rtype_seq");

        // Table of instructions with hand-derived counts
        for (int i = 0; i < 10; i++) begin
            run_fixed($sformatf("tbl%0d", i), tbl[i]);
        end

        // Branch then JAL through the model
        opcode = 7'b1100011;
        model_instr(7'b1100011, 0, 0, 1'b1, 1'b1, 0);
        run_q("branch_seq");
        opcode = 7'b1101111;
        model_instr(7'b1101111, 0, 0, 1'b1, 1'b1, 0);
        run_q("jal_seq");

        // Random legal instructions with random wait states
        for (int i = 0; i < 40; i++) begin
            op = legal_ops[$urandom_range(0, 7)];
            opcode = op;
            model_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'b1, 0);
            run_q("random");
        end

        // Illegal opcodes on the full-featured instance
        do_reset(0);
        opcode = 7'b1111111;
        model_instr(7'b1111111, $urandom_range(0, 2), 0, 1'b1, 1'b1, 25);
        run_q("trap_ones");
        do_reset(0);
        opcode = 7'b0110001;
        model_instr(7'b0110001, 0, 0, 1'b1, 1'b1, 5);
        run_q("trap_low_bits");

        // Parameter-disabled opcodes on the reduced instance
        do_reset(1);
        opcode = 7'b0110111;
        model_instr(7'b0110111, 1, 0, 1'b0, 1'b0, 22);
        run_q("trap_lui_disabled");
        do_reset(1);
        opcode = 7'b1101111;
        model_instr(7'b1101111, 0, 0, 1'b0, 1'b0, 5);
        run_q("trap_jal_disabled");
        do_reset(1);
        opcode = 7'b0110011;
        model_instr(7'b0110011, 0, 0, 1'b0, 1'b0, 0);
        run_q("reduced_rtype");

        // Reset in the middle of a store wait
        do_reset(0);
        opcode = 7'b0100011;
        guard = 0;
        do begin
            @(negedge clk);
            mem_ready = (cur.st == S_FETCH);
            #1;
            guard++;
        end while (cur.st != S_MEM_WR && guard < 20);
        c = blank(S_MEM_WR); c.mem_req = 1'b1; c.mem_we = 1'b1; c.iord = 1'b1;
        check("mid_wr_before", wsel, c);
        #2;
        rst1_n = 1'b0;
        #1;
        check("mid_wr_async_drop", wsel, blank(S_RESET));
        @(negedge clk);
        rst1_n = 1'b1;
        #1;
        check("mid_wr_release", wsel, blank(S_RESET));
        @(posedge clk);
        #1;
        c = blank(S_FETCH); c.mem_req = 1'b1; c.a = 2'b11; c.b = 2'b01;
        check("mid_wr_refetch", wsel, c);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main decoder for the RV32I core.
- A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, so the core can share one memory port and one ALU.
- Waits on a memory ready handshake, so it tolerates any number of memory wait states.
- Adds JAL and LUI/AUIPC support, each enabled by a parameter, plus a sticky illegal-opcode trap.
- Sits between the instruction register's opcode field and the datapath muxes and enables.

Parameters:
- ALUOP_W, 2, width of alu_op.
- HAS_JAL, 1, when 0, opcode 1101111 is treated as illegal.
- HAS_U, 1, when 0, opcodes 0110111 (LUI) and 0010111 (AUIPC) are treated as illegal.
- STATE_W, 4, width of the state encoding and of dbg_state.

Ports:
- clk  in  1  core clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0]; valid from the DECODE state onward.
- mem_ready  in  1  memory has completed the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, qualified by mem_req.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR and oldPC.
- mdr_write  out  1  load MDR.
- pc_write  out  1  unconditional PC write.
- pc_write_cond  out  1  PC write when ALU zero/compare is true.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- alu_src_a  out  2  ALU A input: 00 = rs1, 01 = oldPC, 10 = zero, 11 = PC.
- alu_src_b  out  2  ALU B input: 00 = rs2, 01 = constant 4, 10 = imm.
- alu_op  out  ALUOP_W  00 = add, 01 = branch compare, 10 = funct-decoded.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  2  writeback source: 00 = ALUOut, 01 = MDR, 10 = PC.
- illegal  out  1  sticky trap flag.
- dbg_state  out  STATE_W  current state.

Behaviour:
- Reset: rst_n low forces state RESET and illegal=0. In RESET every output is 0.
- RESET always moves to FETCH on the next clock.
- Outputs are decoded combinationally from the state register only (Moore). Any output not listed for a state is 0.
- FETCH: mem_req=1, iord=0, alu_src_a=11, alu_src_b=01, alu_op=00.
  - Stays in FETCH while mem_ready=0.
  - When mem_ready=1: ir_write=1 and pc_write=1 (pc_src=0) in that cycle, then go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=10, alu_op=00, which precomputes the branch/JAL target into ALUOut. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else, or an opcode disabled by parameter -> TRAP
- EXEC_R: alu_src_a=00, alu_src_b=00, alu_op=10, then WB_ALU.
- EXEC_I: alu_src_a=00, alu_src_b=10, alu_op=10, then WB_ALU.
- LUI: alu_src_a=10, alu_src_b=10, alu_op=00, then WB_ALU.
- AUIPC: alu_src_a=01, alu_src_b=10, alu_op=00, then WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=00, then FETCH.
- MEM_ADDR: alu_src_a=00, alu_src_b=10, alu_op=00. Goes to MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req=1, iord=1. Holds while mem_ready=0. When mem_ready=1: mdr_write=1, then WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=01, then FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Holds while mem_ready=0, then FETCH.
- BRANCH: alu_src_a=00, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=1, then FETCH.
- JAL: reg_write=1, mem_to_reg=10 (PC already holds oldPC+4), pc_write=1, pc_src=1, then FETCH.
- TRAP: absorbing state. illegal=1 and all other outputs 0. Exits only via reset.
- Cycle counts with zero wait states (mem_ready high on first request):
  - branch 3, JAL 3
  - R-type, I-type, LUI, AUIPC 4
  - store 4
  - load 5
  - Each memory wait cycle adds exactly one cycle.
- mem_ready is ignored in every state without mem_req.
- Reset asserted mid-instruction, including mid-wait: outputs drop to 0 asynchronously. No partial write is committed after the reset edge.
- opcode bits [1:0] other than 11 decode as illegal.

Decomposition:
- Shared package holds:
  - opcode constants (existing R/I/LD/S/B/J values, plus LUI and AUIPC);
  - the state enumeration;
  - localparams for every mux-select encoding: ALUSRC_A_*, ALUSRC_B_*, MEMTOREG_*, ALUOP_*.
- No sub-module. A single FSM with a next-state block and an output-decode block is the natural structure.

Test Plan:
- Reset, then R-type (0110011), mem_ready tied 1 -> states RESET, FETCH, DECODE, EXEC_R, WB_ALU, FETCH. reg_write=1 only in WB_ALU, with mem_to_reg=00.
- Load (0000011), mem_ready low 2 cycles in FETCH and 3 cycles in MEM_RD -> total 10 cycles. mdr_write pulses once; WB_MEM has reg_write=1, mem_to_reg=01.
- Store (0100011) -> MEM_WR holds mem_we=1 and iord=1 until mem_ready. reg_write never asserts. Returns to FETCH.
- Branch, then JAL (HAS_JAL=1) -> BRANCH asserts pc_write_cond=1, pc_src=1, alu_op=01. JAL asserts reg_write=1, mem_to_reg=10, pc_write=1. Each takes 3 cycles.
- HAS_U=0 with opcode 0110111, and separately opcode 1111111 -> DECODE goes to TRAP. illegal=1 held for 20+ cycles, all enables 0.
- rst_n pulsed low mid-MEM_WR -> mem_req and mem_we go to 0 immediately. After release, RESET then FETCH, illegal=0.
